jpeg_byte_out_ctrl: RTL and testbench

Read-side controller for the 32-bit entropy-coded output FIFO (sync_fifo_32). It fetches words with a single-outstanding read handshake and serializes each word MSB-byte first onto a byte stream with valid/ready flow control. It applies JPEG byte stuffing (0xFF -> 0xFF 0x00) and, on request, appends the EOI marker 0xFF 0xD9 once the FIFO has drained. It sits between the FIFO and the bitstream output interface.

---
 rtl/jpeg_byte_out_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_jpeg_byte_out_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_byte_out_ctrl.sv
// jpeg_byte_out_ctrl
// Read-side controller for the 32-bit entropy-coded output FIFO. It fetches
// one word at a time (single outstanding read) and serializes it MSB byte
// first onto a valid/ready byte stream. When enabled, every 0xFF data byte is
// followed by a stuffed 0x00. After eoi_req, once the FIFO reads empty, the
// EOI marker 0xFF 0xD9 is appended.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   fifo_read_req       one-cycle read strobe to the FIFO
//   fifo_read_data      FIFO word, qualified by fifo_rdata_valid
//   fifo_empty          FIFO empty flag (looked at only while idle)
//   fifo_rdata_valid    FIFO read data valid
//   eoi_req             pulse: close the stream after the FIFO drains
//   out_byte/out_valid  byte stream, held stable while out_ready=0
//   out_ready           downstream accept
//   byte_count          bytes accepted downstream (wraps)
//   done                pulse after the 0xD9 marker byte is accepted
//   rd_err              sticky read-timeout flag
module jpeg_byte_out_ctrl #(
  parameter logic        STUFF_EN   = 1'b1,
  parameter int unsigned RD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fifo_read_req,
  input  logic [31:0] fifo_read_data,
  input  logic        fifo_empty,
  input  logic        fifo_rdata_valid,
  input  logic        eoi_req,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] byte_count,
  output logic        done,
  output logic        rd_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_SEND, S_STUFF, S_EOI_FF, S_EOI_D9
  } state_t;

  localparam logic [7:0] TMO_LIM = 8'(RD_TIMEOUT);

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  tmo_q, tmo_d;
  logic        eoi_pend_q, eoi_pend_d;
  logic [31:0] byte_count_q, byte_count_d;
  logic        rd_err_q, rd_err_d;
  logic        done_q, done_d;
  logic        read_req_q, read_req_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_byte_q, out_byte_d;
  logic        acc;

  function automatic logic [7:0] pick(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    pick = w[31:24];
      2'd1:    pick = w[23:16];
      2'd2:    pick = w[15:8];
      default: pick = w[7:0];
    endcase
  endfunction

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    idx_d        = idx_q;
    tmo_d        = tmo_q;
    eoi_pend_d   = eoi_pend_q;
    byte_count_d = byte_count_q;
    rd_err_d     = rd_err_q;
    done_d       = 1'b0;
    acc          = out_valid_q & out_ready;

    if (acc) byte_count_d = byte_count_q + 32'd1;
    // A repeat request while already pending simply re-sets the flag.
    if (eoi_req) eoi_pend_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!fifo_empty)     state_d = S_REQ;
        else if (eoi_pend_q) state_d = S_EOI_FF;
      end
      S_REQ: begin
        state_d = S_WAIT;
        tmo_d   = 8'd0;
      end
      S_WAIT: begin
        if (fifo_rdata_valid) begin
          word_d  = fifo_read_data;
          idx_d   = 2'd0;
          state_d = S_SEND;
        end else begin
          tmo_d = tmo_q + 8'd1;
          // Give up on this read; the word is lost and nothing is emitted.
          if (tmo_q + 8'd1 == TMO_LIM) begin
            rd_err_d = 1'b1;
            state_d  = S_IDLE;
          end
        end
      end
      S_SEND: begin
        if (acc) begin
          if (STUFF_EN && out_byte_q == 8'hFF) state_d = S_STUFF;
          else if (idx_q == 2'd3)              state_d = S_IDLE;
          else                                 idx_d   = idx_q + 2'd1;
        end
      end
      S_STUFF: begin
        if (acc) begin
          if (idx_q == 2'd3) state_d = S_IDLE;
          else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_SEND;
          end
        end
      end
      S_EOI_FF: if (acc) state_d = S_EOI_D9;
      S_EOI_D9: begin
        if (acc) begin
          done_d     = 1'b1;
          eoi_pend_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered: decode them from the next state so they line
    // up with the state register and hold naturally during stalls.
    read_req_d  = (state_d == S_REQ);
    out_valid_d = 1'b0;
    out_byte_d  = 8'h00;
    case (state_d)
      S_SEND:   begin out_valid_d = 1'b1; out_byte_d = pick(word_d, idx_d); end
      S_STUFF:  begin out_valid_d = 1'b1; out_byte_d = 8'h00; end
      S_EOI_FF: begin out_valid_d = 1'b1; out_byte_d = 8'hFF; end
      S_EOI_D9: begin out_valid_d = 1'b1; out_byte_d = 8'hD9; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      word_q       <= 32'd0;
      idx_q        <= 2'd0;
      tmo_q        <= 8'd0;
      eoi_pend_q   <= 1'b0;
      byte_count_q <= 32'd0;
      rd_err_q     <= 1'b0;
      done_q       <= 1'b0;
      read_req_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_byte_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      tmo_q        <= tmo_d;
      eoi_pend_q   <= eoi_pend_d;
      byte_count_q <= byte_count_d;
      rd_err_q     <= rd_err_d;
      done_q       <= done_d;
      read_req_q   <= read_req_d;
      out_valid_q  <= out_valid_d;
      out_byte_q   <= out_byte_d;
    end
  end

  assign fifo_read_req = read_req_q;
  assign out_valid     = out_valid_q;
  assign out_byte      = out_byte_q;
  assign byte_count    = byte_count_q;
  assign done          = done_q;
  assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_jpeg_byte_out_ctrl.sv
module tb_jpeg_byte_out_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fifo_read_req;
  logic [31:0] fifo_read_data = 32'd0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rdata_valid = 1'b0;
  logic        eoi_req = 1'b0;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] byte_count;
  logic        done;
  logic        rd_err;

  // second instance with stuffing disabled, driven by hand
  logic        req1;
  logic [31:0] data1 = 32'd0;
  logic        empty1 = 1'b1;
  logic        valid1 = 1'b0;
  logic [7:0]  byte1;
  logic        ovalid1;
  logic [31:0] cnt1;
  logic        done1;
  logic        err1;

  jpeg_byte_out_ctrl #(.STUFF_EN(1'b1), .RD_TIMEOUT(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_read_req(fifo_read_req),
    .fifo_read_data(fifo_read_data), .fifo_empty(fifo_empty),
    .fifo_rdata_valid(fifo_rdata_valid), .eoi_req(eoi_req),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready),
    .byte_count(byte_count), .done(done), .rd_err(rd_err)
  );

  jpeg_byte_out_ctrl #(.STUFF_EN(1'b0), .RD_TIMEOUT(16)) u_nostuff (
    .clk(clk), .rst(rst), .fifo_read_req(req1),
    .fifo_read_data(data1), .fifo_empty(empty1),
    .fifo_rdata_valid(valid1), .eoi_req(1'b0),
    .out_byte(byte1), .out_valid(ovalid1), .out_ready(1'b1),
    .byte_count(cnt1), .done(done1), .rd_err(err1)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  sb[$];      // expected accepted bytes, in order
  logic [31:0] fq[$];      // FIFO model contents
  int          acc_cyc[$]; // cycle numbers of accepted bytes
  int          cyc = 0;
  int          done_cnt = 0;
  int          req_cnt = 0;
  logic        hold_valid = 1'b0;
  logic        rd_pend = 1'b0;
  logic [31:0] rd_word = 32'd0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  // Reference serializer: expected byte stream for one word with stuffing.
  task automatic push_exp(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] b;
      b = w[31-8*i -: 8];
      sb.push_back(b);
      if (b == 8'hFF) sb.push_back(8'h00);
    end
  endtask

  // FIFO model: pop on the read strobe, data valid one cycle later.
  initial begin
    forever begin
      @(negedge clk);
      if (fifo_read_req && fq.size() > 0) begin
        rd_word = fq.pop_front();
        rd_pend = 1'b1;
      end
    end
  end
  initial begin
    forever begin
      @(posedge clk); #1;
      fifo_rdata_valid = rd_pend && !hold_valid;
      fifo_read_data   = rd_word;
      rd_pend          = 1'b0;
      fifo_empty       = (fq.size() == 0);
    end
  end

  // Monitor: scoreboard compare on acceptance, stall stability, pulse counts.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) prev_stall = 1'b0;
      else begin
        if (prev_stall) begin
          chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
          chk("stall_byte_held", {24'd0, out_byte}, {24'd0, prev_byte});
        end
        if (out_valid && out_ready) begin
          acc_cyc.push_back(cyc);
          if (sb.size() == 0) chk("unexpected_byte", {24'd0, out_byte}, 32'hFFFF_FFFF);
          else chk("stream_byte", {24'd0, out_byte}, {24'd0, sb.pop_front()});
        end
        prev_stall = out_valid && !out_ready;
        prev_byte  = out_byte;
        if (done) done_cnt++;
        if (fifo_read_req) req_cnt++;
      end
      cyc++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_valid(input string nm);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin tick(1); k++; end
    if (!out_valid) chk(nm, 32'd0, 32'd1);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 200) begin tick(1); k++; end
    if (sb.size() != 0) chk(nm, sb.size(), 32'd0);
    tick(4);
  endtask

  typedef struct {
    logic [31:0] word;
    logic        toggle;   // apply the stall pattern instead of ready=1
    int          exp_len;  // bytes on the wire for this word
  } vec_t;

  initial begin
    vec_t vt[5];
    int   pat[7];
    int   exp_cnt;
    int   r0, d0;
    logic seen;
    logic [7:0] got1[$];

    vt[0] = '{32'h0A0B0C0D, 1'b0, 4};
    vt[1] = '{32'h12FF34FF, 1'b0, 6};
    vt[2] = '{32'hAABBCCDD, 1'b1, 4};
    vt[3] = '{32'hFFFFFFFF, 1'b0, 8};
    vt[4] = '{32'hFF000000, 1'b0, 5};
    pat = '{1, 0, 0, 1, 0, 1, 1};

    #2 rst = 1'b1;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_read_req", {31'd0, fifo_read_req}, 32'd0);
    chk("rst_byte_count", byte_count, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd_err", {31'd0, rd_err}, 32'd0);
    tick(2);
    rst = 1'b0;
    tick(2);

    // Table-driven single words.
    exp_cnt = 0;
    for (int v = 0; v < 5; v++) begin
      acc_cyc.delete();
      r0 = req_cnt;
      push_exp(vt[v].word);
      exp_cnt += vt[v].exp_len;
      if (vt[v].toggle) begin
        out_ready = 1'b0;
        fq.push_back(vt[v].word);
        wait_valid("toggle_wait_valid");
        for (int p = 0; p < 7; p++) begin
          out_ready = pat[p][0];
          tick(1);
        end
        out_ready = 1'b1;
      end else begin
        fq.push_back(vt[v].word);
      end
      drain("vec_drain");
      chk("vec_byte_count", byte_count, exp_cnt);
      chk("vec_read_pulses", req_cnt - r0, 32'd1);
      if (!vt[v].toggle && acc_cyc.size() == vt[v].exp_len)
        chk("vec_no_bubble", acc_cyc[acc_cyc.size()-1] - acc_cyc[0], vt[v].exp_len - 1);
      else if (!vt[v].toggle)
        chk("vec_accept_count", acc_cyc.size(), vt[v].exp_len);
    end

    // Reset while the second byte of a word is stalled.
    out_ready = 1'b0;
    push_exp(32'h11223344);
    fq.push_back(32'h11223344);
    wait_valid("rst_mid_wait_valid");
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    tick(2);
    chk("rst_mid_stalled_byte", {24'd0, out_byte}, 32'h22);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_mid_out_byte", {24'd0, out_byte}, 32'd0);
    chk("rst_mid_byte_count", byte_count, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    push_exp(32'h55667788);
    fq.push_back(32'h55667788);
    drain("post_rst_drain");
    chk("post_rst_byte_count", byte_count, 32'd4);

    // EOI after two queued words; a second eoi_req while pending is ignored.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    d0 = done_cnt;
    push_exp(32'd10);
    push_exp(32'd20);
    sb.push_back(8'hFF);
    sb.push_back(8'hD9);
    fq.push_back(32'd10);
    fq.push_back(32'd20);
    wait_valid("eoi_wait_valid");
    eoi_req = 1'b1;
    tick(1);
    eoi_req = 1'b0;
    tick(1);
    eoi_req = 1'b1;
    tick(1);
    eoi_req = 1'b0;
    drain("eoi_drain");
    chk("eoi_byte_count", byte_count, 32'd10);
    chk("eoi_done_pulses", done_cnt - d0, 32'd1);
    tick(6);
    chk("eoi_no_repeat", sb.size() + (out_valid ? 1 : 0), 32'd0);

    // Stuffing disabled: 0xFF bytes pass through untouched.
    empty1 = 1'b0;
    begin
      int k;
      k = 0;
      while (!req1 && k < 20) begin tick(1); k++; end
      chk("nostuff_read_req", {31'd0, req1}, 32'd1);
    end
    empty1 = 1'b1;
    tick(1);
    valid1 = 1'b1;
    data1  = 32'h12FF34FF;
    tick(1);
    valid1 = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (ovalid1) got1.push_back(byte1);
      tick(1);
    end
    chk("nostuff_len", got1.size(), 32'd4);
    if (got1.size() == 4) begin
      chk("nostuff_b0", {24'd0, got1[0]}, 32'h12);
      chk("nostuff_b1", {24'd0, got1[1]}, 32'hFF);
      chk("nostuff_b2", {24'd0, got1[2]}, 32'h34);
      chk("nostuff_b3", {24'd0, got1[3]}, 32'hFF);
    end
    chk("nostuff_byte_count", cnt1, 32'd4);

    // Read timeout: data valid never returns.
    hold_valid = 1'b1;
    fq.push_back(32'h01020304);
    begin
      int k;
      k = 0;
      while (!fifo_read_req && k < 20) begin tick(1); k++; end
      chk("tmo_read_req", {31'd0, fifo_read_req}, 32'd1);
    end
    seen = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (out_valid) seen = 1'b1;
    end
    chk("tmo_not_yet", {31'd0, rd_err}, 32'd0);
    tick(1);
    chk("tmo_rd_err", {31'd0, rd_err}, 32'd1);
    for (int k = 0; k < 20; k++) begin
      tick(1);
      if (out_valid) seen = 1'b1;
    end
    chk("tmo_sticky", {31'd0, rd_err}, 32'd1);
    chk("tmo_no_valid", {31'd0, seen}, 32'd0);
    hold_valid = 1'b0;
    rst = 1'b1;
    tick(1);
    chk("tmo_cleared_by_rst", {31'd0, rd_err}, 32'd0);
    rst = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
